// File: rtl/resq_dispatch_server.sv
// Dispatch server: accepts the selector's winner, pops its source queue and hands it to the lowest free rescue unit.
// Optional build macro DISPATCH_STATS_EN adds saturating per-queue serve counters.
module resq_dispatch_server #(
    parameter int NUM_UNITS = 4,
    parameter int TIMER_W   = 8,
    parameter int BASE_TIME = 20,
    parameter int FAST_TIME = 8,
    localparam int UW       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 In_Valid,
    input  logic                 In_Boost,
    input  logic [1:0]           In_Priority,
    input  logic [7:0]           In_Zone,
    input  logic                 In_Select_Shelter,
    output logic                 Serve_Shelter,
    output logic                 Serve_Food,
    output logic                 Dispatch_Valid,
    output logic [UW-1:0]        Dispatch_Unit,
    output logic [7:0]           Dispatch_Zone,
    output logic [1:0]           Dispatch_Priority,
    output logic [NUM_UNITS-1:0] Units_Busy,
`ifdef DISPATCH_STATS_EN
    output logic [15:0]          Shelter_Count,
    output logic [15:0]          Food_Count,
`endif
    output logic [NUM_UNITS-1:0] Done_Mask
);

    typedef enum logic [1:0] {IDLE, SERVE, SETTLE} state_t;

    // A zero mission length would never expire, so it is clamped to one cycle.
    localparam logic [TIMER_W-1:0] BASE_LOAD =
        (TIMER_W'(BASE_TIME) == '0) ? TIMER_W'(1) : TIMER_W'(BASE_TIME);
    localparam logic [TIMER_W-1:0] FAST_LOAD =
        (TIMER_W'(FAST_TIME) == '0) ? TIMER_W'(1) : TIMER_W'(FAST_TIME);

    state_t                 state_q, state_d;
    logic                   alloc_fire;
    logic [UW-1:0]          free_idx;
    logic                   any_free;
    logic [UW-1:0]          unit_q;
    logic [7:0]             zone_q;
    logic [1:0]             prio_q;
    logic                   sel_q;
    logic [NUM_UNITS-1:0]   busy_q, busy_d;
    logic [NUM_UNITS-1:0]   done_q, expire;
    logic [TIMER_W-1:0]     timer_q [NUM_UNITS];
    logic [TIMER_W-1:0]     timer_d [NUM_UNITS];
    logic [TIMER_W-1:0]     load_val;

    assign any_free = ~(&busy_q);
    assign load_val = In_Boost ? FAST_LOAD : BASE_LOAD;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = UW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        alloc_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (In_Valid && any_free) begin
                    state_d    = SERVE;
                    alloc_fire = 1'b1;
                end
            end
            SERVE:   state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            unit_q  <= '0;
            zone_q  <= '0;
            prio_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (alloc_fire) begin
                unit_q <= free_idx;
                zone_q <= In_Zone;
                prio_q <= In_Priority;
                sel_q  <= In_Select_Shelter;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            logic load_here;
            assign load_here   = alloc_fire && (free_idx == UW'(gi));
            assign expire[gi]  = busy_q[gi] && (timer_q[gi] == TIMER_W'(1));
            assign busy_d[gi]  = load_here || (busy_q[gi] && !expire[gi]);
            assign timer_d[gi] = load_here  ? load_val :
                                 expire[gi] ? '0 :
                                 busy_q[gi] ? timer_q[gi] - TIMER_W'(1) : timer_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++) timer_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= expire;
            for (int i = 0; i < NUM_UNITS; i++) timer_q[i] <= timer_d[i];
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [15:0] shelter_cnt_q, food_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shelter_cnt_q <= '0;
            food_cnt_q    <= '0;
        end else if (state_q == SERVE) begin
            if (sel_q && shelter_cnt_q != 16'hFFFF) shelter_cnt_q <= shelter_cnt_q + 16'd1;
            if (!sel_q && food_cnt_q != 16'hFFFF)   food_cnt_q    <= food_cnt_q + 16'd1;
        end
    end

    assign Shelter_Count = shelter_cnt_q;
    assign Food_Count    = food_cnt_q;
`endif

    assign Serve_Shelter     = (state_q == SERVE) && sel_q;
    assign Serve_Food        = (state_q == SERVE) && !sel_q;
    assign Dispatch_Valid    = (state_q == SERVE);
    assign Dispatch_Unit     = unit_q;
    assign Dispatch_Zone     = zone_q;
    assign Dispatch_Priority = prio_q;
    assign Units_Busy        = busy_q;
    assign Done_Mask         = done_q;

endmodule

// File: tb/tb_resq_dispatch_server.sv
// Self-checking bench for resq_dispatch_server: directed table, multi-cycle corner sequences, random run vs. timeline model.
module tb_resq_dispatch_server;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       In_Valid = 1'b0;
    logic       In_Boost = 1'b0;
    logic [1:0] In_Priority = '0;
    logic [7:0] In_Zone = '0;
    logic       In_Select_Shelter = 1'b0;
    logic       Serve_Shelter, Serve_Food, Dispatch_Valid;
    logic [1:0] Dispatch_Unit;
    logic [7:0] Dispatch_Zone;
    logic [1:0] Dispatch_Priority;
    logic [3:0] Units_Busy, Done_Mask;
`ifdef DISPATCH_STATS_EN
    logic [15:0] Shelter_Count, Food_Count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    resq_dispatch_server dut (
        .clk(clk), .rst(rst),
        .In_Valid(In_Valid), .In_Boost(In_Boost), .In_Priority(In_Priority),
        .In_Zone(In_Zone), .In_Select_Shelter(In_Select_Shelter),
        .Serve_Shelter(Serve_Shelter), .Serve_Food(Serve_Food),
        .Dispatch_Valid(Dispatch_Valid), .Dispatch_Unit(Dispatch_Unit),
        .Dispatch_Zone(Dispatch_Zone), .Dispatch_Priority(Dispatch_Priority),
        .Units_Busy(Units_Busy),
`ifdef DISPATCH_STATS_EN
        .Shelter_Count(Shelter_Count), .Food_Count(Food_Count),
`endif
        .Done_Mask(Done_Mask)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        In_Valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       boost;
        logic       sel;
        logic [7:0] zone;
        logic [1:0] prio;
        logic       exp_sh;
        logic       exp_fd;
        int         exp_mission;
    } vec_t;

    vec_t tbl[4];

    // Timeline model: a unit is described only by the edge at which its mission ends.
    int         busy_until[4];
    int         next_ok;
    int         k;
    logic       m_sh, m_fd, m_dv;
    logic [1:0] m_unit, m_prio;
    logic [7:0] m_zone;
    logic [3:0] m_busy, m_done;
    int         m_scnt, m_fcnt;

    task automatic model_reset();
        for (int u = 0; u < 4; u++) busy_until[u] = -1;
        next_ok = 0; k = 0;
        m_sh = 0; m_fd = 0; m_dv = 0; m_unit = 0; m_prio = 0; m_zone = 0;
        m_busy = 0; m_done = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_edge();
        int pick;
        if (m_sh && m_scnt < 65535) m_scnt++;
        if (m_fd && m_fcnt < 65535) m_fcnt++;
        m_sh = 0; m_fd = 0; m_dv = 0;
        pick = -1;
        for (int u = 0; u < 4; u++) m_done[u] = (busy_until[u] == k);
        if (In_Valid && k >= next_ok) begin
            for (int u = 3; u >= 0; u--) if (busy_until[u] <= k - 1) pick = u;
        end
        if (pick >= 0) begin
            busy_until[pick] = k + (In_Boost ? 8 : 20);
            next_ok = k + 3;
            m_sh = In_Select_Shelter; m_fd = !In_Select_Shelter; m_dv = 1;
            m_unit = 2'(pick); m_zone = In_Zone; m_prio = In_Priority;
        end
        for (int u = 0; u < 4; u++) m_busy[u] = (busy_until[u] > k);
        k++;
    endtask

    initial begin
        int n, c, nserve;
        int s_cyc[5];
        int s_unit[5];
        int d_cyc[4];
        logic [23:0] act_v, exp_v;

        tbl[0] = '{1'b0, 1'b1, 8'h2A, 2'd1, 1'b1, 1'b0, 20};
        tbl[1] = '{1'b1, 1'b0, 8'h51, 2'd3, 1'b0, 1'b1, 8};
        tbl[2] = '{1'b1, 1'b1, 8'hC3, 2'd2, 1'b1, 1'b0, 8};
        tbl[3] = '{1'b0, 1'b0, 8'h07, 2'd0, 1'b0, 1'b1, 20};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {Serve_Shelter, Serve_Food, Dispatch_Valid, Dispatch_Unit,
            Dispatch_Zone, Dispatch_Priority, Units_Busy, Done_Mask}, '0);
        rst = 1'b0;

        // Single requests from an idle pool
        for (int i = 0; i < 4; i++) begin
            do_reset();
            In_Valid = 1'b1; In_Boost = tbl[i].boost; In_Select_Shelter = tbl[i].sel;
            In_Zone = tbl[i].zone; In_Priority = tbl[i].prio;
            @(negedge clk);
            In_Valid = 1'b0;
            $display("vec %0d: shelter=%b food=%b unit=%0d zone=%h prio=%0d busy=%b",
                     i, Serve_Shelter, Serve_Food, Dispatch_Unit, Dispatch_Zone, Dispatch_Priority, Units_Busy);
            chk("vec_serve", {Serve_Shelter, Serve_Food, Dispatch_Valid},
                {tbl[i].exp_sh, tbl[i].exp_fd, 1'b1});
            chk("vec_dispatch", {Dispatch_Unit, Dispatch_Zone, Dispatch_Priority},
                {2'd0, tbl[i].zone, tbl[i].prio});
            chk("vec_busy", Units_Busy, 4'b0001);
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                n++;
                if (Done_Mask[0]) break;
            end
            chk("vec_mission_len", n, tbl[i].exp_mission);
            chk("vec_busy_clear", {Units_Busy, Done_Mask}, {4'b0000, 4'b0001});
            @(negedge clk);
            chk("vec_done_pulse_width", Done_Mask, 4'b0000);
        end

        // Reset asserted during SERVE
        do_reset();
        In_Valid = 1'b1; In_Select_Shelter = 1'b1; In_Zone = 8'h99; In_Boost = 1'b0;
        @(negedge clk);
        chk("midserve_pre", Serve_Shelter, 1'b1);
        rst = 1'b1;
        #1;
        chk("midserve_async", {Serve_Shelter, Serve_Food, Dispatch_Valid, Dispatch_Unit,
            Dispatch_Zone, Dispatch_Priority, Units_Busy, Done_Mask}, '0);
        In_Valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (Dispatch_Valid || Serve_Shelter || Serve_Food || Units_Busy != 0) n++;
        end
        chk("midserve_no_pulse_after", n, 0);

        // Continuous In_Valid with five requests into four units
        do_reset();
        In_Valid = 1'b1; In_Select_Shelter = 1'b1; In_Boost = 1'b0; In_Zone = 8'h10;
        nserve = 0;
        for (int u = 0; u < 4; u++) d_cyc[u] = 0;
        for (c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (Dispatch_Valid && nserve < 5) begin
                s_cyc[nserve] = c; s_unit[nserve] = int'(Dispatch_Unit);
                $display("burst dispatch %0d: cycle=%0d unit=%0d", nserve, c, Dispatch_Unit);
                nserve++;
                if (nserve == 5) In_Valid = 1'b0;
            end
            for (int u = 0; u < 4; u++) if (Done_Mask[u] && d_cyc[u] == 0) d_cyc[u] = c;
        end
        chk("burst_count", nserve, 5);
        if (nserve == 5) begin
            chk("burst_cycles", {s_cyc[0][7:0], s_cyc[1][7:0], s_cyc[2][7:0], s_cyc[3][7:0], s_cyc[4][7:0]},
                {8'd1, 8'd4, 8'd7, 8'd10, 8'd22});
            chk("burst_units", {s_unit[0][3:0], s_unit[1][3:0], s_unit[2][3:0], s_unit[3][3:0], s_unit[4][3:0]},
                {4'd0, 4'd1, 4'd2, 4'd3, 4'd0});
        end
        chk("burst_done_stagger", {d_cyc[0][7:0], d_cyc[1][7:0]}, {8'd21, 8'd24});

        // Randomized run against the timeline model
        do_reset();
        model_reset();
        n = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            In_Valid = ($urandom_range(0, 9) < 6);
            In_Boost = 1'($urandom);
            In_Select_Shelter = 1'($urandom);
            In_Zone = 8'($urandom);
            In_Priority = 2'($urandom);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            act_v = {Serve_Shelter, Serve_Food, Dispatch_Valid, Dispatch_Unit, Dispatch_Zone,
                     Dispatch_Priority, Units_Busy, Done_Mask};
            exp_v = {m_sh, m_fd, m_dv, m_unit, m_zone, m_prio, m_busy, m_done};
            if (m_dv && n < 40) begin
                $display("rand dispatch: edge=%0d unit=%0d zone=%h prio=%0d shelter=%b",
                         k - 1, m_unit, m_zone, m_prio, m_sh);
                n++;
            end
            chk("rand_outputs", {40'd0, act_v}, {40'd0, exp_v});
`ifdef DISPATCH_STATS_EN
            chk("rand_counts", {Shelter_Count, Food_Count}, {16'(m_scnt), 16'(m_fcnt)});
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/resq_dispatch_server.md
Name: resq_dispatch_server

Overview:
- Consumer end of the shelter/food arbitration path.
- Takes the winning request from the final selector (valid, boost, priority, zone, select flag). Returns a one-cycle serve pulse to the winning source queue so it pops its head entry.
- Assigns the request to a free rescue unit from a fixed pool. Tracks each unit's mission timer until completion.
- Sits between the selector and the unit status/display logic.

Parameters:
- NUM_UNITS, 4: number of rescue units in the pool (2..8).
- TIMER_W, 8: width of each unit's mission countdown.
- BASE_TIME, 20: mission cycles for a non-boosted request.
- FAST_TIME, 8: mission cycles for a boosted request.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- In_Valid  in  1  selector output valid.
- In_Boost  in  1  winning request boost flag.
- In_Priority  in  2  winning request priority.
- In_Zone  in  8  winning request zone.
- In_Select_Shelter  in  1  1 = winner is shelter, 0 = food.
- Serve_Shelter  out  1  one-cycle pop pulse to the shelter queue.
- Serve_Food  out  1  one-cycle pop pulse to the food queue.
- Dispatch_Valid  out  1  one-cycle pulse; a unit was assigned.
- Dispatch_Unit  out  $clog2(NUM_UNITS)  index of the assigned unit.
- Dispatch_Zone  out  8  zone sent with the assigned unit.
- Dispatch_Priority  out  2  priority of the dispatched request.
- Units_Busy  out  NUM_UNITS  per-unit busy flags.
- Done_Mask  out  NUM_UNITS  one-cycle pulse per unit finishing its mission.

Behaviour:
- Reset (async, any time): FSM to IDLE. All timers 0. All outputs 0. Any captured request is discarded. Upstream queues are not popped.
- FSM states: IDLE, SERVE, SETTLE.
- IDLE -> SERVE when In_Valid=1 and (~Units_Busy) != 0. At that edge:
  - Capture zone, priority, boost and select flag.
  - Allocate the lowest-index free unit.
  - Load its timer: In_Boost ? FAST_TIME : BASE_TIME. A load value of 0 is forced to 1.
  - Set its busy bit.
- SERVE (1 cycle):
  - Exactly one of Serve_Shelter/Serve_Food = 1, chosen by the captured select flag.
  - Dispatch_Valid = 1; Dispatch_Unit/Zone/Priority show the captured values.
  - Always -> SETTLE.
- SETTLE (1 cycle): no outputs pulse. Gives the upstream queue heads and the selector one cycle to update. Always -> IDLE.
- Throughput: at most one dispatch per 3 cycles. Latency from In_Valid sampled to serve pulse: 1 cycle.
- In_Valid is ignored outside IDLE. A request that drops after capture is still served.
- Pool full (all busy): stay in IDLE. No pulses. The request remains pending upstream.
- Timers: each busy unit decrements every cycle. When its timer is 1, on the next edge:
  - busy clears;
  - timer becomes 0;
  - the matching Done_Mask bit pulses for one cycle.
- Multiple completions in the same cycle assert multiple Done_Mask bits.
- Free detection uses registered Units_Busy. A unit finishing at edge N can be allocated at edge N+1 at the earliest.
- Serve_Shelter and Serve_Food are never high together. Dispatch_Valid coincides exactly with the serve pulse.
- Dispatch_Unit/Zone/Priority hold their last values between pulses (0 after reset).

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- Defined: adds outputs Shelter_Count[15:0] and Food_Count[15:0].
  - Each increments on its serve pulse and saturates at 16'hFFFF.
  - Both cleared by rst.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset mid-SERVE: assert rst during the SERVE cycle -> all outputs 0 immediately; Units_Busy=0; no serve pulse after rst releases.
- Single shelter request (In_Valid=1, Select_Shelter=1, Zone=8'h2A, Boost=0, idle pool) -> next cycle Serve_Shelter=1, Dispatch_Unit=0, Dispatch_Zone=8'h2A; Units_Busy=4'b0001. Done_Mask[0] pulses 20 cycles after Units_Busy[0] rises.
- Boosted food request (Boost=1, Select_Shelter=0) -> Serve_Food pulse only; unit busy for exactly 8 cycles (FAST_TIME) before Done_Mask bit.
- Continuous In_Valid with 5 requests, 4 units -> serve pulses at cycles 1, 4, 7, 10 to units 0..3. The 5th waits with no pulses until the first Done_Mask, then goes to the freed unit 1 cycle later.
- Two units dispatched 0 cycles apart in mission length (same BASE_TIME, pulses 3 cycles apart) -> distinct Done_Mask bits 3 cycles apart. Forcing equal finish via parameters gives both bits in the same cycle.
- DISPATCH_STATS_EN defined: 3 shelter + 2 food dispatches -> Shelter_Count=3, Food_Count=2. Preloaded at 16'hFFFF, stays 16'hFFFF after a further serve.
